lcd_bus_arbiter: RTL and testbench
==================================

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameter EN_CYC, default 26; meaning: lcd_en high width and low-hold width per nibble, in clk cycles (>=1).
REQ-002 Parameter EXEC_CYC, default 2000; meaning: post-byte execution wait for normal bytes (40 us at 50 MHz) (>=1).
REQ-003 Parameter LONG_CYC, default 80000; meaning: post-byte wait for clear/home commands (1.6 ms at 50 MHz) (>=1).
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command byte offered (RS=0).
REQ-007 cmd_data  input  8  command byte.
REQ-008 cmd_ready  output  1  command accepted this cycle when cmd_valid is also high.
REQ-009 dat_valid  input  1  data byte offered (RS=1).
REQ-010 dat_data  input  8  data byte.
REQ-011 dat_ready  output  1  data accepted this cycle when dat_valid is also high.
REQ-012 lcd_rs  output  1  HD44780 register select, registered.
REQ-013 lcd_en  output  1  HD44780 enable strobe, registered.
REQ-014 lcd_d  output  4  HD44780 D7..D4 nibble bus, registered.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states: IDLE, SETUP_H, EN_H, HOLD_H, SETUP_L, EN_L, HOLD_L, EXEC; encoding is free.
REQ-017 Arbitration is combinational in IDLE only: one requester valid -> that port wins; both valid -> the port not granted last wins; last_grant resets to "dat", so cmd wins the first tie.
REQ-018 cmd_ready/dat_ready are high only in IDLE, only for the winning port, and never both high at once; both are low in all other states.
REQ-019 A transfer occurs on the cycle valid&&ready; the byte, its RS value (0 cmd, 1 dat) and the long/short flag are latched; last_grant is updated; the next state is SETUP_H.
REQ-020 Long flag set only for cmd-port bytes 0x01, 0x02 and 0x03 (byte[7:2]==0 and byte!=0); 0x00 and all data bytes use EXEC_CYC.
REQ-021 SETUP_H: 1 cycle; lcd_rs=latched RS, lcd_d=byte[7:4], lcd_en=0.
REQ-022 EN_H: exactly EN_CYC cycles with lcd_en=1.
REQ-023 HOLD_H: exactly EN_CYC cycles with lcd_en=0.
REQ-024 SETUP_L: 1 cycle; lcd_d=byte[3:0], lcd_en=0.
REQ-025 EN_L: EN_CYC cycles with lcd_en=1; HOLD_L: EN_CYC cycles with lcd_en=0.
REQ-026 EXEC: exactly LONG_CYC cycles (long flag) or EXEC_CYC cycles, lcd_en=0, then IDLE.
REQ-027 lcd_rs and lcd_d are stable throughout every EN_x/HOLD_x interval and hold their last values in EXEC and IDLE.
REQ-028 Latency: a byte accepted in cycle t allows the earliest next acceptance in cycle t+3+4*EN_CYC+wait, where wait is EXEC_CYC or LONG_CYC.
REQ-029 A single 20-bit down-counter times all states; parameters exceeding 2^20-1 are unsupported.
REQ-030 Valid dropping or data changing while busy has no effect; bytes are never partially sent or duplicated.
REQ-031 Back-to-back requests: when valid is held high, the port is re-arbitrated in the IDLE cycle following EXEC, with no extra idle cycle.

Reset
REQ-032 rst_n low asynchronously forces: state IDLE, lcd_en=0, lcd_rs=0, lcd_d=0, busy=0, counter=0, last_grant="dat", and all latched bytes/flags to 0.
REQ-033 Reset mid-byte abandons the byte; no completion is signalled; after release, arbitration restarts from the REQ-032 values.
REQ-034 While rst_n is low, cmd_ready and dat_ready are 0.

Verification (EN_CYC=2, EXEC_CYC=5, LONG_CYC=20)
REQ-035 Reset check: hold rst_n low with both valids high -> all outputs 0, both readies 0.
REQ-036 Single command: cmd 0x28 accepted at t -> lcd_rs=0; lcd_d=0x2 during the first 2-cycle en pulse; lcd_d=0x8 during the second pulse; cmd_ready high again at t+16.
REQ-037 Clear command: cmd 0x01 accepted at t -> next ready at t+31; the same test with cmd 0x00 -> next ready at t+16.
REQ-038 Data path: data 0x41 -> lcd_rs=1, nibbles 0x4 then 0x1; data 0x01 uses short wait (ready again at t+16).
REQ-039 Contention: both valids held high with four queued bytes each -> grant order cmd, dat, cmd, dat; never both readies high at once.
REQ-040 Async reset: assert rst_n during EN_H -> lcd_en falls without waiting for clk and busy=0; after release with both valids high, cmd wins first.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// Arbitrates a command port and a data port onto an HD44780 4-bit bus.
// Each byte goes out as two enable-strobed nibbles followed by an execution wait.
module lcd_bus_arbiter #(
  parameter int EN_CYC   = 26,
  parameter int EXEC_CYC = 2000,
  parameter int LONG_CYC = 80000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       dat_valid,
  input  logic [7:0] dat_data,
  output logic       dat_ready,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [3:0] lcd_d,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, SETUP_H, EN_H, HOLD_H, SETUP_L, EN_L, HOLD_L, EXEC
  } state_t;

  localparam logic [19:0] EN_LOAD   = 20'(EN_CYC - 1);
  localparam logic [19:0] EXEC_LOAD = 20'(EXEC_CYC - 1);
  localparam logic [19:0] LONG_LOAD = 20'(LONG_CYC - 1);

  state_t      state_reg, state_next;
  logic [19:0] cnt_reg, cnt_next;
  logic [7:0]  byte_reg, byte_next;
  logic        rs_reg, rs_next;
  logic        long_reg, long_next;
  logic        last_dat_reg, last_dat_next;
  logic        lcd_rs_reg, lcd_rs_next;
  logic        lcd_en_reg, lcd_en_next;
  logic [3:0]  lcd_d_reg, lcd_d_next;

  logic grant_cmd, grant_dat, timer_done;

  // On a tie the port that did not win last time gets the bus.
  assign grant_cmd  = cmd_valid && (!dat_valid || last_dat_reg);
  assign grant_dat  = dat_valid && (!cmd_valid || !last_dat_reg);
  assign cmd_ready  = rst_n && (state_reg == IDLE) && grant_cmd;
  assign dat_ready  = rst_n && (state_reg == IDLE) && grant_dat;
  assign busy       = (state_reg != IDLE);
  assign timer_done = (cnt_reg == 20'd0);

  assign lcd_rs = lcd_rs_reg;
  assign lcd_en = lcd_en_reg;
  assign lcd_d  = lcd_d_reg;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    byte_next     = byte_reg;
    rs_next       = rs_reg;
    long_next     = long_reg;
    last_dat_next = last_dat_reg;
    lcd_rs_next   = lcd_rs_reg;
    lcd_d_next    = lcd_d_reg;
    lcd_en_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cmd_ready) begin
          byte_next     = cmd_data;
          rs_next       = 1'b0;
          long_next     = (cmd_data[7:2] == 6'd0) && (cmd_data[1:0] != 2'd0);
          last_dat_next = 1'b0;
          state_next    = SETUP_H;
        end else if (dat_ready) begin
          byte_next     = dat_data;
          rs_next       = 1'b1;
          long_next     = 1'b0;
          last_dat_next = 1'b1;
          state_next    = SETUP_H;
        end
      end
      SETUP_H: begin
        state_next = EN_H;
        cnt_next   = EN_LOAD;
      end
      EN_H: begin
        if (timer_done) begin
          state_next = HOLD_H;
          cnt_next   = EN_LOAD;
        end else begin
          cnt_next = cnt_reg - 20'd1;
        end
      end
      HOLD_H: begin
        if (timer_done) state_next = SETUP_L;
        else            cnt_next   = cnt_reg - 20'd1;
      end
      SETUP_L: begin
        state_next = EN_L;
        cnt_next   = EN_LOAD;
      end
      EN_L: begin
        if (timer_done) begin
          state_next = HOLD_L;
          cnt_next   = EN_LOAD;
        end else begin
          cnt_next = cnt_reg - 20'd1;
        end
      end
      HOLD_L: begin
        if (timer_done) begin
          state_next = EXEC;
          cnt_next   = long_reg ? LONG_LOAD : EXEC_LOAD;
        end else begin
          cnt_next = cnt_reg - 20'd1;
        end
      end
      EXEC: begin
        if (timer_done) state_next = IDLE;
        else            cnt_next   = cnt_reg - 20'd1;
      end
      default: state_next = IDLE;
    endcase

    // Pins are registered from the next state so they line up with the state itself.
    if (state_next == SETUP_H) begin
      lcd_rs_next = rs_next;
      lcd_d_next  = byte_next[7:4];
    end
    if (state_next == SETUP_L) lcd_d_next = byte_reg[3:0];
    lcd_en_next = (state_next == EN_H) || (state_next == EN_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 20'd0;
      byte_reg     <= 8'd0;
      rs_reg       <= 1'b0;
      long_reg     <= 1'b0;
      last_dat_reg <= 1'b1;
      lcd_rs_reg   <= 1'b0;
      lcd_en_reg   <= 1'b0;
      lcd_d_reg    <= 4'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      byte_reg     <= byte_next;
      rs_reg       <= rs_next;
      long_reg     <= long_next;
      last_dat_reg <= last_dat_next;
      lcd_rs_reg   <= lcd_rs_next;
      lcd_en_reg   <= lcd_en_next;
      lcd_d_reg    <= lcd_d_next;
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: directed timing/contention/reset cases plus random
// traffic, all checked against a cycle-offset model of the byte transfer.
module tb_lcd_bus_arbiter;
  localparam int EN = 2;
  localparam int EX = 5;
  localparam int LG = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_ready;
  logic       dat_valid = 1'b0;
  logic [7:0] dat_data = 8'd0;
  logic       dat_ready;
  logic       lcd_rs, lcd_en, busy;
  logic [3:0] lcd_d;

  lcd_bus_arbiter #(.EN_CYC(EN), .EXEC_CYC(EX), .LONG_CYC(LG)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .dat_valid(dat_valid), .dat_data(dat_data), .dat_ready(dat_ready),
    .lcd_rs(lcd_rs), .lcd_en(lcd_en), .lcd_d(lcd_d), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one byte in flight, described by its acceptance cycle.
  bit         model_on = 1'b0;
  int         t_acc = 0;
  int         t_idle = 0;
  logic [7:0] m_byte = 8'd0;
  logic       m_rs = 1'b0;
  bit         m_last_dat = 1'b1;
  int         n_txn = 0;

  always @(negedge clk) begin
    bit fl, ecr, edr, een;
    logic [3:0] ed;
    int k, w;
    if (!rst_n) begin
      t_acc = 0; t_idle = 0; m_byte = 8'd0; m_rs = 1'b0; m_last_dat = 1'b1;
    end else if (model_on) begin
      fl  = (cyc > t_acc) && (cyc < t_idle);
      k   = cyc - t_acc;
      ecr = !fl && cmd_valid && (!dat_valid || m_last_dat);
      edr = !fl && dat_valid && (!cmd_valid || !m_last_dat);
      een = fl && ((k >= 2 && k <= 1 + EN) || (k >= 3 + 2*EN && k <= 2 + 3*EN));
      ed  = (fl && k < 2 + 2*EN) ? m_byte[7:4] : m_byte[3:0];
      chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, ecr});
      chk("dat_ready", {31'b0, dat_ready}, {31'b0, edr});
      chk("both_ready", {31'b0, cmd_ready && dat_ready}, 32'd0);
      chk("busy", {31'b0, busy}, {31'b0, fl});
      chk("lcd_en", {31'b0, lcd_en}, {31'b0, een});
      chk("lcd_rs", {31'b0, lcd_rs}, {31'b0, m_rs});
      chk("lcd_d", {28'b0, lcd_d}, {28'b0, ed});
      if (ecr || edr) begin
        m_byte = ecr ? cmd_data : dat_data;
        m_rs   = edr;
        m_last_dat = edr;
        w = (ecr && m_byte >= 8'd1 && m_byte <= 8'd3) ? LG : EX;
        t_acc  = cyc;
        t_idle = cyc + 3 + 4*EN + w;
        n_txn++;
        $display("txn %0d: cycle %0d port=%s byte=%02h wait=%0d",
                 n_txn, cyc, edr ? "dat" : "cmd", m_byte, w);
      end
    end
  end

  task automatic send(input bit is_dat, input logic [7:0] b, output int t);
    @(posedge clk); #1;
    if (is_dat) begin dat_valid = 1'b1; dat_data = b; end
    else        begin cmd_valid = 1'b1; cmd_data = b; end
    t = -1;
    for (int i = 0; i < 200 && t < 0; i++) begin
      @(negedge clk);
      if (is_dat ? dat_ready : cmd_ready) t = cyc;
    end
    if (t < 0) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    dat_valid = 1'b0;
  endtask

  typedef struct { bit is_dat; logic [7:0] b; int gap; } gap_t;
  gap_t gaps[5] = '{'{1'b0, 8'h28, 16}, '{1'b0, 8'h01, 31}, '{1'b0, 8'h00, 16},
                    '{1'b1, 8'h41, 16}, '{1'b1, 8'h01, 16}};
  logic [7:0] cq[4] = '{8'h38, 8'h0C, 8'h06, 8'h80};
  logic [7:0] dq[4] = '{8'h48, 8'h69, 8'h21, 8'h02};

  initial begin
    int t1, t2, ci, di, ng, ta;
    // Reset with both requesters active.
    cmd_valid = 1'b1; dat_valid = 1'b1; cmd_data = 8'hFF; dat_data = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_lcd_en", {31'b0, lcd_en}, 32'd0);
    chk("rst_lcd_rs", {31'b0, lcd_rs}, 32'd0);
    chk("rst_lcd_d", {28'b0, lcd_d}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_dat_ready", {31'b0, dat_ready}, 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0; dat_valid = 1'b0;
    rst_n = 1'b1;
    model_on = 1'b1;

    // Back-to-back pairs give the accept-to-accept latency.
    foreach (gaps[i]) begin
      send(gaps[i].is_dat, gaps[i].b, t1);
      send(gaps[i].is_dat, gaps[i].b, t2);
      chk($sformatf("gap_%02h", gaps[i].b), t2 - t1, gaps[i].gap);
    end

    // Contention: last grant was dat, so cmd wins first and they alternate.
    ci = 0; di = 0; ng = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; dat_valid = 1'b1; cmd_data = cq[0]; dat_data = dq[0];
    for (int i = 0; i < 400 && ng < 8; i++) begin
      @(negedge clk);
      if ((cmd_valid && cmd_ready) || (dat_valid && dat_ready)) begin
        chk("grant_order", {31'b0, dat_ready}, ng % 2);
        if (dat_ready) di++; else ci++;
        ng++;
      end
      @(posedge clk); #1;
      cmd_valid = (ci < 4); dat_valid = (di < 4);
      if (ci < 4) cmd_data = cq[ci];
      if (di < 4) dat_data = dq[di];
    end
    chk("contention_count", ng, 8);
    cmd_valid = 1'b0; dat_valid = 1'b0;

    // Random traffic; data also churns while the arbiter is busy.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      cmd_valid = ($urandom_range(0, 2) == 0);
      dat_valid = ($urandom_range(0, 2) == 0);
      cmd_data  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      dat_data  = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'($urandom);
    end
    @(posedge clk); #1;
    dat_valid = 1'b0; cmd_valid = 1'b1; cmd_data = 8'h33;

    // Asynchronous reset in the middle of the first enable pulse.
    ta = -1;
    for (int i = 0; i < 300 && ta < 0; i++) begin
      @(negedge clk);
      if (cmd_ready) ta = cyc;
    end
    chk("arst_accept", {31'b0, ta >= 0}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("arst_pre_en", {31'b0, lcd_en}, 32'd1);
    #2;
    model_on = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_lcd_en", {31'b0, lcd_en}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_lcd_d", {28'b0, lcd_d}, 32'd0);
    chk("arst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1; dat_valid = 1'b1; cmd_data = 8'h0F; dat_data = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold_ready", {31'b0, cmd_ready || dat_ready}, 32'd0);
    rst_n = 1'b1;
    model_on = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("post_rst_dat_ready", {31'b0, dat_ready}, 32'd0);
    repeat (60) @(posedge clk);
    #1;
    cmd_valid = 1'b0; dat_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
